// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared state, opcode and datapath-select encodings
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_LUI,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/ctrl_next_state.sv
// rtl/ctrl_next_state.sv - combinational next-state logic of the multicycle controller
module ctrl_next_state
  import multicycle_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [6:0] i_op,
  input  logic       i_mem_ready,
  output state_t     o_next
);

  always_comb begin
    o_next = i_state;
    case (i_state)
      S_FETCH:    o_next = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_op)
          OP_LOAD, OP_STORE: o_next = S_MEMADR;
          OP_RTYPE:          o_next = S_EXECR;
          OP_ITYPE:          o_next = S_EXECI;
          OP_BRANCH:         o_next = S_BRANCH;
          OP_JAL:            o_next = S_JAL;
          OP_LUI:            o_next = S_LUI;
          default:           o_next = S_TRAP;
        endcase
      end
      // op is still held in the IR, so it selects load vs store here
      S_MEMADR:   o_next = (i_op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  o_next = i_mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    o_next = S_FETCH;
      S_MEMWRITE: o_next = i_mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    o_next = S_ALUWB;
      S_EXECI:    o_next = S_ALUWB;
      S_ALUWB:    o_next = S_FETCH;
      S_BRANCH:   o_next = S_FETCH;
      S_JAL:      o_next = S_ALUWB;
      S_LUI:      o_next = S_ALUWB;
      S_TRAP:     o_next = S_TRAP;
      default:    o_next = S_TRAP;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV-subset control FSM: state register and output decode
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       take_branch,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal
);

  state_t r_state;
  state_t w_next_state;

  ctrl_next_state u_next_state (
    .i_state     (r_state),
    .i_op        (op),
    .i_mem_ready (mem_ready),
    .o_next      (w_next_state)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // Handshake-qualified strobes follow mem_ready/take_branch in the same cycle
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    result_src = RES_ALUOUT;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_MDR;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECR: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_op     = ALU_SUB;
        pc_write   = take_branch;
        instr_done = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
      end
      S_LUI: begin
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
      end
      S_TRAP:  illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       take_branch;
  logic       mem_ready;
  logic       pc_write, ir_write, reg_write, mem_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic       instr_done, illegal;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .take_branch (take_branch),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .mem_write   (mem_write),
    .adr_src     (adr_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .result_src  (result_src),
    .alu_op      (alu_op),
    .instr_done  (instr_done),
    .illegal     (illegal)
  );

  // {pc_w, ir_w, reg_w, mem_w, adr, a[2], b[2], res[2], aluop[2], done, illegal}
  localparam logic [14:0] E_FETCH1 = 15'b1_1_0_0_0_00_10_10_00_0_0;
  localparam logic [14:0] E_FETCH0 = 15'b0_0_0_0_0_00_10_10_00_0_0;
  localparam logic [14:0] E_DEC    = 15'b0_0_0_0_0_01_01_00_00_0_0;
  localparam logic [14:0] E_MADR   = 15'b0_0_0_0_0_10_01_00_00_0_0;
  localparam logic [14:0] E_MRD    = 15'b0_0_0_0_1_00_00_00_00_0_0;
  localparam logic [14:0] E_MWB    = 15'b0_0_1_0_0_00_00_01_00_1_0;
  localparam logic [14:0] E_MWR0   = 15'b0_0_0_1_1_00_00_00_00_0_0;
  localparam logic [14:0] E_MWR1   = 15'b0_0_0_1_1_00_00_00_00_1_0;
  localparam logic [14:0] E_EXR    = 15'b0_0_0_0_0_10_00_00_10_0_0;
  localparam logic [14:0] E_EXI    = 15'b0_0_0_0_0_10_01_00_10_0_0;
  localparam logic [14:0] E_AWB    = 15'b0_0_1_0_0_00_00_00_00_1_0;
  localparam logic [14:0] E_BR1    = 15'b1_0_0_0_0_10_00_00_01_1_0;
  localparam logic [14:0] E_BR0    = 15'b0_0_0_0_0_10_00_00_01_1_0;
  localparam logic [14:0] E_JAL    = 15'b1_0_0_0_0_01_10_00_00_0_0;
  localparam logic [14:0] E_LUI    = 15'b0_0_0_0_0_11_01_00_00_0_0;
  localparam logic [14:0] E_TRAP   = 15'b0_0_0_0_0_00_00_00_00_0_1;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] LU = 7'b0110111, BAD = 7'b1111111;

  typedef struct {
    logic        rst;
    logic [6:0]  opc;
    logic        tb;
    logic        mr;
    logic [14:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [14:0] outs();
    return {pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
            alu_src_b, result_src, alu_op, instr_done, illegal};
  endfunction

  task automatic add(input logic r, input logic [6:0] o, input logic t,
                     input logic m, input logic [14:0] e, input string n);
    vec_t v;
    v.rst = r; v.opc = o; v.tb = t; v.mr = m; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  initial begin
    int mrd_seen, wb_cnt, done_at;

    // R-type, then reset-state FETCH as first row
    add(0, RT, 0, 1, E_FETCH1, "r_fetch");  add(0, RT, 0, 1, E_DEC,  "r_decode");
    add(0, RT, 0, 1, E_EXR,    "r_execr");  add(0, RT, 0, 1, E_AWB,  "r_aluwb");
    add(0, IT, 0, 1, E_FETCH1, "i_fetch");  add(0, IT, 0, 1, E_DEC,  "i_decode");
    add(0, IT, 0, 1, E_EXI,    "i_execi");  add(0, IT, 0, 1, E_AWB,  "i_aluwb");
    add(0, LU, 0, 1, E_FETCH1, "lui_fetch"); add(0, LU, 0, 1, E_DEC, "lui_decode");
    add(0, LU, 0, 1, E_LUI,    "lui_exec"); add(0, LU, 0, 1, E_AWB,  "lui_aluwb");
    // load with fetch stall, mem_ready ignored in DECODE/MEMADR/MEMWB, 3-cycle read stall
    add(0, LW, 0, 0, E_FETCH0, "lw_fetch_stall"); add(0, LW, 0, 1, E_FETCH1, "lw_fetch");
    add(0, LW, 0, 0, E_DEC,    "lw_decode"); add(0, LW, 0, 0, E_MADR, "lw_memadr");
    add(0, LW, 0, 0, E_MRD,    "lw_rd_w1");  add(0, LW, 0, 0, E_MRD,  "lw_rd_w2");
    add(0, LW, 0, 0, E_MRD,    "lw_rd_w3");  add(0, LW, 0, 1, E_MRD,  "lw_rd_go");
    add(0, LW, 0, 0, E_MWB,    "lw_memwb");
    // store with 2-cycle write stall
    add(0, SW, 0, 1, E_FETCH1, "sw_fetch"); add(0, SW, 0, 1, E_DEC,  "sw_decode");
    add(0, SW, 0, 1, E_MADR,   "sw_memadr"); add(0, SW, 0, 0, E_MWR0, "sw_wr_w1");
    add(0, SW, 0, 0, E_MWR0,   "sw_wr_w2"); add(0, SW, 0, 1, E_MWR1, "sw_wr_go");
    // branches: take_branch ignored outside BRANCH
    add(0, BR, 1, 1, E_FETCH1, "br_fetch"); add(0, BR, 1, 1, E_DEC, "br_decode_tb1");
    add(0, BR, 1, 1, E_BR1,    "br_taken"); add(0, BR, 1, 0, E_FETCH0, "br_fetch_tb1");
    add(0, BR, 0, 1, E_FETCH1, "br_fetch2"); add(0, BR, 0, 1, E_DEC, "br_decode2");
    add(0, BR, 0, 1, E_BR0,    "br_not_taken");
    // jal
    add(0, JL, 0, 1, E_FETCH1, "jal_fetch"); add(0, JL, 0, 1, E_DEC, "jal_decode");
    add(0, JL, 0, 1, E_JAL,    "jal_exec");  add(0, JL, 0, 1, E_AWB, "jal_aluwb");
    // reset during a store wait
    add(0, SW, 0, 1, E_FETCH1, "swr_fetch"); add(0, SW, 0, 1, E_DEC, "swr_decode");
    add(0, SW, 0, 1, E_MADR,   "swr_memadr"); add(0, SW, 0, 0, E_MWR0, "swr_wait");
    add(1, SW, 0, 0, E_MWR0,   "swr_wait_rst"); add(0, SW, 0, 0, E_FETCH0, "swr_after_rst");
    // illegal opcode, absorbing trap, reset exit
    add(0, BAD, 0, 1, E_FETCH1, "bad_fetch"); add(0, BAD, 0, 1, E_DEC, "bad_decode");
    for (int k = 0; k < 10; k++) add(0, BAD, k[0], k[1], E_TRAP, $sformatf("trap_%0d", k));
    add(1, BAD, 1, 1, E_TRAP,   "trap_rst"); add(0, BAD, 0, 0, E_FETCH0, "trap_after_rst");

    reset = 1'b1; op = 7'b0; take_branch = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; op = vecs[i].opc;
      take_branch = vecs[i].tb; mem_ready = vecs[i].mr;
      #1;
      chk(vecs[i].name, {17'b0, outs()}, {17'b0, vecs[i].exp});
    end

    // load with 3 stall cycles: one MDR writeback, retire in cycle 7
    mrd_seen = 0; wb_cnt = 0; done_at = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      reset = 1'b0; op = LW; take_branch = 1'b0; mem_ready = 1'b1;
      #1;
      if (adr_src && !mem_write && mrd_seen < 3) begin
        mem_ready = 1'b0;
        mrd_seen++;
        #1;
      end
      if (reg_write && result_src == 2'b01) wb_cnt++;
      if (instr_done && done_at < 0) done_at = c;
    end
    chk("lw_seq_mdr_writebacks", wb_cnt, 1);
    chk("lw_seq_retire_cycle", done_at, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
